// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int ADD_W = 8;

endpackage

// File: rtl/serial_adder_f_adder.sv
// One-bit full-adder cell; the whole datapath of the serial adder is one of these.
module f_adder (
  input  logic cin,
  input  logic x,
  input  logic y,
  output logic s,
  output logic cout
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    s    = x ^ y ^ cin;
    cout = (x & y) | (cin & (x ^ y));
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: operands are shifted LSB first through a single
// full-adder cell, one bit per clock, with the ripple carry held in a flop.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for start; operands captured on an accepted start
//   ST_RUN   | one operand bit per edge through the cell, W edges total
//   ST_DONE  | result registers valid, done pulses for this one cycle
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = ADD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  // Sized so W-1 is representable without wrapping before the compare.
  localparam int CW = $clog2(W) + 1;

  logic [1:0]    state;
  logic [W-1:0]  ra;
  logic [W-1:0]  rb;
  logic [W-1:0]  rs;
  logic [W-1:0]  rs_shift;
  logic          carry;
  logic          cmsb;
  logic [CW-1:0] cnt;
  logic          bit_s;
  logic          bit_c;
  logic          last_bit;

  f_adder u_cell (
    .cin  (carry),
    .x    (ra[0]),
    .y    (rb[0]),
    .s    (bit_s),
    .cout (bit_c)
  );

  // New sum bit enters at the MSB; a 1-bit build has nothing to shift.
  generate
    if (W == 1) begin : g_rs_w1
      assign rs_shift = bit_s;
    end else begin : g_rs_wn
      assign rs_shift = {bit_s, rs[W-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == CW'(W - 1));

  // FSM, operand/sum shifters, ripple carry and bit counter.
  // The result registers load on the final RUN edge so they are already
  // valid in the cycle where done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      carry <= 1'b0;
      cmsb  <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            carry <= cin;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          rs    <= rs_shift;
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          carry <= bit_c;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            cmsb  <= carry;
            sum   <= rs_shift;
            cout  <= bit_c;
            ovf   <= carry ^ bit_c;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main scenarios
// and a 1-bit instance for the single-cell corner case.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic         start1;
  logic         a1;
  logic         b1;
  logic         cin1;
  logic         busy1;
  logic         done1;
  logic         sum1;
  logic         cout1;
  logic         ovf1;

  int n_checks;
  int n_fail;

  serial_adder #(.W(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  serial_adder #(.W(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1),
    .ovf   (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation from IDLE; returns the result seen with done and the
  // number of edges from the accepting edge to done (-1 if it never came).
  // Operands are scrambled right after acceptance.
  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       output logic [W-1:0] rsum, output logic rcout, output logic rovf,
                       output int lat);
    int n;
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~va; b = va ^ vb; cin = ~vc;
    n = 0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        lat = n;
        break;
      end
    end
    rsum = sum; rcout = cout; rovf = ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    #12;
    n_checks++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [W-1:0] s; logic c, o; int lat;
    do_op(8'h5A, 8'h3C, 1'b0, s, c, o, lat);
    n_checks++;
    if (lat !== W) begin
      n_fail++; $display("FAIL basic_latency: got %0d cycles, want %0d", lat, W);
    end
    n_checks++;
    if ({s, c, o} !== {8'h96, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL basic_5a_3c: got sum=%h cout=%b ovf=%b, want 96/0/1", s, c, o);
    end
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_pulse: got done=%b busy=%b after pulse, want 0/0", done, busy);
    end
  endtask

  task automatic test_carry;
    logic [W-1:0] s; logic c, o; int lat;
    do_op(8'hFF, 8'h01, 1'b0, s, c, o, lat);
    n_checks++;
    if (lat !== W || {s, c, o} !== {8'h00, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL carry_ff_01: got sum=%h cout=%b ovf=%b lat=%0d, want 00/1/0 lat 8", s, c, o, lat);
    end
    do_op(8'hFF, 8'h00, 1'b1, s, c, o, lat);
    n_checks++;
    if (lat !== W || {s, c, o} !== {8'h00, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL carry_ff_00_cin: got sum=%h cout=%b ovf=%b lat=%0d, want 00/1/0 lat 8", s, c, o, lat);
    end
  endtask

  task automatic test_overflow;
    logic [W-1:0] s; logic c, o; int lat;
    do_op(8'h80, 8'h80, 1'b0, s, c, o, lat);
    n_checks++;
    if (lat !== W || {s, c, o} !== {8'h00, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL ovf_80_80: got sum=%h cout=%b ovf=%b lat=%0d, want 00/1/1 lat 8", s, c, o, lat);
    end
    do_op(8'h7F, 8'h00, 1'b1, s, c, o, lat);
    n_checks++;
    if (lat !== W || {s, c, o} !== {8'h80, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL ovf_7f_cin: got sum=%h cout=%b ovf=%b lat=%0d, want 80/0/1 lat 8", s, c, o, lat);
    end
  endtask

  // Second start during RUN must be dropped; previous result held meanwhile.
  task automatic test_busy_ignore;
    int ndone;
    logic [W-1:0] s_seen;
    logic [W-1:0] s_mid;
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; s_seen = '0; s_mid = '0;
    for (int i = 1; i <= 15; i++) begin
      if (i == 2) begin
        a = 8'hFF; b = 8'hFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (i == 4) s_mid = sum;
      if (done) begin
        ndone++;
        s_seen = sum;
      end
    end
    start = 1'b0;
    n_checks++;
    if (s_mid !== 8'h80) begin
      n_fail++; $display("FAIL hold_during_run: got sum=%h mid-run, want previous 80", s_mid);
    end
    n_checks++;
    if (ndone !== 1) begin
      n_fail++; $display("FAIL busy_single_done: got %0d done pulses, want 1", ndone);
    end
    n_checks++;
    if (s_seen !== 8'h33) begin
      n_fail++; $display("FAIL busy_ignore_sum: got sum=%h, want 33", s_seen);
    end
  endtask

  task automatic test_back_to_back;
    int cyc_q[$];
    int ndone_bad;
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    ndone_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc_q.push_back(i);
        if (sum !== 8'h03) ndone_bad++;
      end
    end
    start = 1'b0;
    n_checks++;
    if (cyc_q.size() !== 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d done pulses in 40 cycles, want 4", cyc_q.size());
    end
    for (int k = 1; k < cyc_q.size(); k++) begin
      n_checks++;
      if (cyc_q[k] - cyc_q[k-1] !== 10) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d cycles between done pulses, want 10", cyc_q[k] - cyc_q[k-1]);
      end
    end
    n_checks++;
    if (ndone_bad !== 0) begin
      n_fail++; $display("FAIL b2b_sum: got %0d results not equal 03, want 0", ndone_bad);
    end
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort;
    logic [W-1:0] s; logic c, o; int lat;
    int ndone;
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                         busy, done, sum, cout, ovf);
    end
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d cycles with busy/done in reset, want 0", ndone);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h01, 8'h01, 1'b0, s, c, o, lat);
    n_checks++;
    if (lat !== W || {s, c, o} !== {8'h02, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL abort_fresh_add: got sum=%h cout=%b ovf=%b lat=%0d, want 02/0/0 lat 8", s, c, o, lat);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] s; logic c, o; int lat;
    logic [W-1:0] va, vb; logic vc;
    logic [W:0] ref_full;
    logic ref_ovf;
    int nbad;
    nbad = 0;
    for (int i = 0; i < 1000; i++) begin
      va = W'($urandom); vb = W'($urandom); vc = 1'($urandom);
      ref_full = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
      ref_ovf  = (va[W-1] == vb[W-1]) && (ref_full[W-1] != va[W-1]);
      do_op(va, vb, vc, s, c, o, lat);
      n_checks++;
      if (lat !== W || {c, s} !== ref_full || o !== ref_ovf) begin
        n_fail++; nbad++;
        if (nbad <= 5)
          $display("FAIL random_op: %h+%h+%b got sum=%h cout=%b ovf=%b lat=%0d, want %h/%b/%b lat 8",
                   va, vb, vc, s, c, o, lat, ref_full[W-1:0], ref_full[W], ref_ovf);
      end
    end
  endtask

  task automatic test_w1;
    logic exp_s, exp_c, exp_o;
    logic [2:0] v;
    int lat;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      exp_s = v[2] ^ v[1] ^ v[0];
      exp_c = (v[2] & v[1]) | (v[0] & (v[2] ^ v[1]));
      exp_o = v[0] ^ exp_c;
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~v[2]; b1 = ~v[1]; cin1 = ~v[0];
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
        @(posedge clk); #1;
        if (done1) begin
          lat = i;
          break;
        end
      end
      n_checks++;
      if (lat !== 1 || {sum1, cout1, ovf1} !== {exp_s, exp_c, exp_o}) begin
        n_fail++; $display("FAIL w1_op: a=%b b=%b cin=%b got sum=%b cout=%b ovf=%b lat=%0d, want %b/%b/%b lat 1",
                           v[2], v[1], v[0], sum1, cout1, ovf1, lat, exp_s, exp_c, exp_o);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_basic;
    test_carry;
    test_overflow;
    test_busy_ignore;
    test_back_to_back;
    test_reset_abort;
    test_w1;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
